// File: rtl/mdc_operand_dispatch_pkg.sv
// mdc_dispatch_package: shared types and defaults for the operand dispatcher.
//   MAC_CNT_LEN_DEF / NVEC_W_DEF : default element and vector-count limits
//   state_t                      : dispatcher FSM states
//   cfg_t                        : configuration latched when start is accepted
package mdc_dispatch_package;
    localparam int MAC_CNT_LEN_DEF = 4096;
    localparam int NVEC_W_DEF      = 16;
    localparam int LEN_W_DEF       = $clog2(MAC_CNT_LEN_DEF);

    typedef enum logic [2:0] {
        IDLE,
        BIAS,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // Sized by the package defaults; instances must not use larger limits.
    typedef struct packed {
        logic [LEN_W_DEF-1:0]  len;
        logic [NVEC_W_DEF-1:0] num_vec;
        logic                  bias_en;
    } cfg_t;
endpackage

// File: rtl/mdc_operand_dispatch_if.sv
// mdc_operand_dispatch_if: command, configuration and stream signals of the
// operand dispatcher.
//   master : upstream/downstream environment (drives start, config, in/bias
//            streams and the a/b/c readies)
//   slave  : the dispatcher itself
interface mdc_operand_dispatch_if
    import mdc_dispatch_package::*;
#(
    parameter int MAC_CNT_LEN = MAC_CNT_LEN_DEF,
    parameter int NVEC_W      = NVEC_W_DEF
);
    localparam int LW = $clog2(MAC_CNT_LEN);

    logic              start;
    logic [LW-1:0]     reg_len;
    logic [NVEC_W-1:0] reg_num_vec;
    logic              reg_bias_en;
    logic              in_TVALID;
    logic              in_TREADY;
    logic [63:0]       in_TDATA;
    logic              bias_TVALID;
    logic              bias_TREADY;
    logic [31:0]       bias_TDATA;
    logic              a_TVALID;
    logic              a_TREADY;
    logic [31:0]       a_TDATA;
    logic              b_TVALID;
    logic              b_TREADY;
    logic [31:0]       b_TDATA;
    logic              c_TVALID;
    logic              c_TREADY;
    logic [31:0]       c_TDATA;
    logic              busy;
    logic              done;

    modport master (
        output start, reg_len, reg_num_vec, reg_bias_en,
        output in_TVALID, in_TDATA, bias_TVALID, bias_TDATA,
        output a_TREADY, b_TREADY, c_TREADY,
        input  in_TREADY, bias_TREADY,
        input  a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA,
        input  busy, done
    );

    modport slave (
        input  start, reg_len, reg_num_vec, reg_bias_en,
        input  in_TVALID, in_TDATA, bias_TVALID, bias_TDATA,
        input  a_TREADY, b_TREADY, c_TREADY,
        output in_TREADY, bias_TREADY,
        output a_TVALID, a_TDATA, b_TVALID, b_TDATA, c_TVALID, c_TDATA,
        output busy, done
    );
endinterface

// File: rtl/mdc_operand_dispatch_stream_reg.sv
// mdc_stream_reg: one-entry valid/ready output register.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   load, din        : write a new word (caller only loads when ~valid | ready)
//   ready            : downstream ready
//   valid, dout      : registered output word
// A load in the same cycle as a transfer keeps valid high and replaces the
// data, so the stage sustains one word per cycle. Data holds while stalled.
module mdc_stream_reg #(
    parameter int W = 32
) (
    input  logic         ap_clk,
    input  logic         ap_rst_n,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] dout
);
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/mdc_operand_dispatch.sv
// mdc_operand_dispatch: splits a packed {b,a} operand stream into separate a/b
// streams plus an optional per-vector bias c stream, framed as num_vec vectors
// of len+1 elements per start command.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   bus (slave)      : start/config, in and bias inputs, a/b/c outputs,
//                      busy and done status
module mdc_operand_dispatch
    import mdc_dispatch_package::*;
#(
    parameter int MAC_CNT_LEN = MAC_CNT_LEN_DEF,
    parameter int NVEC_W      = NVEC_W_DEF
) (
    input logic                   ap_clk,
    input logic                   ap_rst_n,
    mdc_operand_dispatch_if.slave bus
);
    localparam int LW = $clog2(MAC_CNT_LEN);

    state_t            state;
    cfg_t              cfg;
    logic [LW-1:0]     elem_cnt;
    logic [NVEC_W-1:0] vec_cnt;
    logic [NVEC_W:0]   vec_nxt;
    logic              busy_q, done_q;
    logic              ab_valid, c_valid;
    logic [63:0]       ab_data;
    logic [31:0]       c_data;
    logic              ab_ready, in_rdy, bias_rdy, in_hs, bias_hs;
    logic              last_elem, last_vec;

    assign ab_ready = bus.a_TREADY & bus.b_TREADY;
    assign in_rdy   = (state == STREAM) & (~ab_valid | ab_ready);
    assign bias_rdy = (state == BIAS) & (~c_valid | bus.c_TREADY);
    assign in_hs    = bus.in_TVALID & in_rdy;
    assign bias_hs  = bus.bias_TVALID & bias_rdy;

    // One extra bit so num_vec = 2^NVEC_W-1 terminates without wrapping.
    assign vec_nxt   = {1'b0, vec_cnt} + {{NVEC_W{1'b0}}, 1'b1};
    assign last_vec  = vec_nxt == {1'b0, NVEC_W'(cfg.num_vec)};
    assign last_elem = elem_cnt == LW'(cfg.len);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state    <= IDLE;
            cfg      <= '0;
            elem_cnt <= '0;
            vec_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    cfg.len     <= LEN_W_DEF'(bus.reg_len);
                    cfg.num_vec <= NVEC_W_DEF'(bus.reg_num_vec);
                    cfg.bias_en <= bus.reg_bias_en;
                    elem_cnt    <= '0;
                    vec_cnt     <= '0;
                    if (bus.reg_num_vec == '0) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else begin
                        busy_q <= 1'b1;
                        state  <= bus.reg_bias_en ? BIAS : STREAM;
                    end
                end
                BIAS: if (bias_hs) state <= STREAM;
                STREAM: if (in_hs) begin
                    if (last_elem) begin
                        elem_cnt <= '0;
                        vec_cnt  <= vec_nxt[NVEC_W-1:0];
                        if (last_vec)         state <= DRAIN;
                        else if (cfg.bias_en) state <= BIAS;
                    end else begin
                        elem_cnt <= elem_cnt + 1'b1;
                    end
                end
                // Completion is reported only after both output stages empty.
                DRAIN: if (!ab_valid && !c_valid) begin
                    state  <= DONE;
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    mdc_stream_reg #(.W(64)) u_ab (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .load    (in_hs),
        .din     (bus.in_TDATA),
        .ready   (ab_ready),
        .valid   (ab_valid),
        .dout    (ab_data)
    );

    mdc_stream_reg #(.W(32)) u_c (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .load    (bias_hs),
        .din     (bus.bias_TDATA),
        .ready   (bus.c_TREADY),
        .valid   (c_valid),
        .dout    (c_data)
    );

    assign bus.in_TREADY   = in_rdy;
    assign bus.bias_TREADY = bias_rdy;
    assign bus.a_TVALID    = ab_valid;
    assign bus.b_TVALID    = ab_valid;
    assign bus.a_TDATA     = ab_data[31:0];
    assign bus.b_TDATA     = ab_data[63:32];
    assign bus.c_TVALID    = c_valid;
    assign bus.c_TDATA     = c_data;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_mdc_operand_dispatch.sv
module tb_mdc_operand_dispatch;
    logic ap_clk = 1'b0;
    logic ap_rst_n = 1'b0;
    always #5 ap_clk = ~ap_clk;

    mdc_operand_dispatch_if #(.MAC_CNT_LEN(4096), .NVEC_W(16)) bus ();

    mdc_operand_dispatch #(.MAC_CNT_LEN(4096), .NVEC_W(16)) dut (
        .ap_clk  (ap_clk),
        .ap_rst_n(ap_rst_n),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.start       = 1'b0;
        bus.in_TVALID   = 1'b0;
        bus.in_TDATA    = '0;
        bus.bias_TVALID = 1'b0;
        bus.bias_TDATA  = '0;
    endtask

    // Modes: 0 random valid/ready, 1 directed data + always ready/valid,
    //        2 a ready, b toggling, 3 random data + always ready/valid.
    task automatic run_frame(input int len, input int nvec, input bit bias_en,
                             input int mode, input bit perturb);
        logic [63:0] src[$];
        logic [31:0] bq[$];
        int n, nb, in_ptr, out_ptr, b_ptr, c_ptr, done_cnt;
        int last_in_cyc, done_cyc, first_out, last_out;
        bit fin, ab_stall, c_stall, ab_hs, in_hs, c_hs, bias_hs;
        logic [63:0] held_ab;
        logic [31:0] held_c;
        n  = (len + 1) * nvec;
        nb = bias_en ? nvec : 0;
        for (int i = 0; i < n; i++)
            src.push_back(mode == 1 ? {32'(2*i+2), 32'(2*i+1)} : {$urandom, $urandom});
        for (int k = 0; k < nb; k++) bq.push_back(32'(100 * (k + 1)));
        in_ptr = 0; out_ptr = 0; b_ptr = 0; c_ptr = 0; done_cnt = 0;
        last_in_cyc = -1; done_cyc = -1; first_out = -1; last_out = -1;
        fin = 0; ab_stall = 0; c_stall = 0; held_ab = '0; held_c = '0;

        @(negedge ap_clk);
        bus.reg_len     = 12'(len);
        bus.reg_num_vec = 16'(nvec);
        bus.reg_bias_en = bias_en;
        bus.start       = 1'b1;
        @(posedge ap_clk);
        #1 bus.start = 1'b0;

        for (int cyc = 0; cyc < n * 10 + 100 && !fin; cyc++) begin
            @(negedge ap_clk);
            case (mode)
                0: begin
                    bus.a_TREADY = ($urandom % 3) != 0;
                    bus.b_TREADY = ($urandom % 3) != 0;
                    bus.c_TREADY = ($urandom % 3) != 0;
                end
                2: begin
                    bus.a_TREADY = 1'b1;
                    bus.b_TREADY = cyc[0];
                    bus.c_TREADY = 1'b1;
                end
                default: begin
                    bus.a_TREADY = 1'b1;
                    bus.b_TREADY = 1'b1;
                    bus.c_TREADY = 1'b1;
                end
            endcase
            bus.in_TVALID   = (in_ptr < n) && (mode != 0 || ($urandom % 4) != 0);
            bus.in_TDATA    = (in_ptr < n) ? src[in_ptr] : {$urandom, $urandom};
            bus.bias_TVALID = (b_ptr < nb) && (mode != 0 || ($urandom % 2) != 0);
            bus.bias_TDATA  = (b_ptr < nb) ? bq[b_ptr] : $urandom;
            if (perturb) begin
                bus.reg_len     = 12'($urandom);
                bus.reg_num_vec = 16'($urandom);
                bus.start       = ($urandom % 4) == 0;
            end
            #1;
            check("ab_valid_pair", {63'd0, bus.b_TVALID}, {63'd0, bus.a_TVALID});
            check("ready_exclusive", {63'd0, bus.in_TREADY & bus.bias_TREADY}, 64'd0);
            if (bus.a_TVALID && !bus.b_TREADY)
                check("in_ready_stall", {63'd0, bus.in_TREADY}, 64'd0);
            if (!bias_en) check("no_c_valid", {63'd0, bus.c_TVALID}, 64'd0);
            check("busy", {63'd0, bus.busy}, {63'd0, (nvec != 0) && !bus.done});
            if (ab_stall) begin
                check("ab_hold_valid", {63'd0, bus.a_TVALID}, 64'd1);
                check("ab_hold_data", {bus.b_TDATA, bus.a_TDATA}, held_ab);
            end
            if (c_stall) begin
                check("c_hold_valid", {63'd0, bus.c_TVALID}, 64'd1);
                check("c_hold_data", {32'd0, bus.c_TDATA}, {32'd0, held_c});
            end
            ab_hs   = bus.a_TVALID && bus.a_TREADY && bus.b_TREADY;
            in_hs   = bus.in_TVALID && bus.in_TREADY;
            c_hs    = bus.c_TVALID && bus.c_TREADY;
            bias_hs = bus.bias_TVALID && bus.bias_TREADY;
            if (ab_hs) begin
                if (out_ptr < n) check("ab_data", {bus.b_TDATA, bus.a_TDATA}, src[out_ptr]);
                else check("ab_extra", 64'(out_ptr), 64'(n - 1));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                out_ptr++;
            end
            if (c_hs) begin
                if (c_ptr < nb) check("c_data", {32'd0, bus.c_TDATA}, {32'd0, bq[c_ptr]});
                else check("c_extra", 64'(c_ptr), 64'(nb - 1));
                c_ptr++;
            end
            if (bias_hs) begin
                check("bias_order", 64'(in_ptr), 64'(b_ptr * (len + 1)));
                b_ptr++;
            end
            if (in_hs) begin
                in_ptr++;
                last_in_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_pairs_out", 64'(out_ptr), 64'(n));
                check("done_bias_out", 64'(c_ptr), 64'(nb));
                fin = 1;
            end
            ab_stall = bus.a_TVALID && !ab_hs;
            held_ab  = {bus.b_TDATA, bus.a_TDATA};
            c_stall  = bus.c_TVALID && !c_hs;
            held_c   = bus.c_TDATA;
            @(posedge ap_clk);
            #1 bus.start = 1'b0;
        end
        idle_inputs();
        check("done_seen", 64'(done_cnt), 64'd1);
        check("pairs_in", 64'(in_ptr), 64'(n));
        check("pairs_out", 64'(out_ptr), 64'(n));
        check("bias_in", 64'(b_ptr), 64'(nb));
        if (nvec == 0) check("nvec0_done_lat", 64'(done_cyc <= 2), 64'd1);
        if ((mode == 1 || mode == 3) && nvec != 0)
            check("done_lat", 64'(done_cyc - last_in_cyc >= 2 && done_cyc - last_in_cyc <= 3), 64'd1);
        if (mode == 1) check("back_to_back", 64'(last_out - first_out), 64'(n - 1));
        for (int k = 0; k < 3; k++) begin
            @(negedge ap_clk);
            check("post_done", {61'd0, bus.done, bus.busy, bus.a_TVALID}, 64'd0);
        end
    endtask

    initial begin
        idle_inputs();
        bus.reg_len = '0; bus.reg_num_vec = '0; bus.reg_bias_en = 1'b0;
        bus.a_TREADY = 1'b1; bus.b_TREADY = 1'b1; bus.c_TREADY = 1'b1;
        #12;
        check("rst_outs", {58'd0, bus.a_TVALID, bus.b_TVALID, bus.c_TVALID,
                           bus.in_TREADY, bus.bias_TREADY, bus.busy}, 64'd0);
        check("rst_data", {bus.b_TDATA, bus.a_TDATA}, 64'd0);
        check("rst_done", {32'd0, bus.c_TDATA} | {63'd0, bus.done}, 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (2) @(negedge ap_clk);

        run_frame(3, 1, 0, 1, 0);
        run_frame(1, 2, 1, 3, 0);
        run_frame(5, 3, 0, 2, 0);
        run_frame(4, 3, 1, 0, 1);
        run_frame(0, 0, 0, 3, 0);
        run_frame(4095, 1, 0, 3, 0);

        // Reset mid-stream after two accepted elements.
        @(negedge ap_clk);
        bus.reg_len = 12'd3; bus.reg_num_vec = 16'd1; bus.reg_bias_en = 1'b0;
        bus.start = 1'b1;
        @(posedge ap_clk);
        #1 bus.start = 1'b0;
        begin
            int acc;
            acc = 0;
            for (int cyc = 0; cyc < 20 && acc < 2; cyc++) begin
                @(negedge ap_clk);
                bus.in_TVALID = 1'b1;
                bus.in_TDATA  = {$urandom, $urandom};
                #1 if (bus.in_TREADY) acc++;
                @(posedge ap_clk);
            end
            check("rst_mid_accepted", 64'(acc), 64'd2);
        end
        #2 ap_rst_n = 1'b0;
        #1;
        check("rst_mid_outs", {58'd0, bus.a_TVALID, bus.b_TVALID, bus.c_TVALID,
                               bus.in_TREADY, bus.bias_TREADY, bus.busy}, 64'd0);
        check("rst_mid_done_data", {bus.b_TDATA, bus.a_TDATA} | {63'd0, bus.done}, 64'd0);
        idle_inputs();
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        run_frame(0, 1, 0, 3, 0);

        run_frame(2, 4, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
